traffic_conflict_monitor: RTL and testbench

TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

---
 rtl/tlc_pkg.sv | 52 +++++
 rtl/tlc_approach_checker.sv | 43 ++++
 rtl/traffic_conflict_monitor.sv | 140 ++++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared light encoding, fault codes, lamp patterns and small decode helpers
// for the traffic conflict monitor.
package tlc_pkg;

   typedef enum logic [1:0] {
      GREEN   = 2'b00,
      YELLOW  = 2'b01,
      RED     = 2'b10,
      INVALID = 2'b11
   } light_t;

   localparam logic [2:0] FC_NONE      = 3'd0;
   localparam logic [2:0] FC_CONFLICT  = 3'd1;
   localparam logic [2:0] FC_INVALID   = 3'd2;
   localparam logic [2:0] FC_ILLEGAL   = 3'd3;
   localparam logic [2:0] FC_SHORT_YEL = 3'd4;

   localparam logic [2:0] LAMP_OFF    = 3'b000;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_RED    = 3'b100;

   function automatic logic [2:0] lamp_decode(input light_t code);
      case (code)
         GREEN:   return LAMP_GREEN;
         YELLOW:  return LAMP_YELLOW;
         RED:     return LAMP_RED;
         default: return LAMP_OFF;
      endcase
   endfunction

   function automatic logic legal_step(input light_t prev, input light_t cur);
      if (prev == cur) return 1'b1;
      case (prev)
         GREEN:   return cur == YELLOW;
         YELLOW:  return cur == RED;
         RED:     return cur == GREEN;
         default: return 1'b0;
      endcase
   endfunction

   // Lowest code wins when several causes coincide.
   function automatic logic [2:0] fault_cause(input logic conflict, input logic invalid,
                                              input logic illegal, input logic short_yel);
      if (conflict)  return FC_CONFLICT;
      if (invalid)   return FC_INVALID;
      if (illegal)   return FC_ILLEGAL;
      if (short_yel) return FC_SHORT_YEL;
      return FC_NONE;
   endfunction

endpackage

// File: rtl/tlc_approach_checker.sv
// Per-approach sequencing check: flags illegal lamp steps and yellow phases
// shorter than MIN_YEL cycles, based on the registered code and its predecessor.
module tlc_approach_checker
   import tlc_pkg::*;
#(
   parameter int MIN_YEL = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] code,
   input  logic       resync,
   output logic       illegal,
   output logic       short_yel
);
   localparam logic [4:0] YEL_FULL = 5'(MIN_YEL);

   light_t     cur;
   light_t     prev;
   logic [4:0] yel_cnt;

   assign cur       = light_t'(code);
   assign illegal   = !legal_step(prev, cur);
   assign short_yel = (prev == YELLOW) && (cur == RED) && (yel_cnt < YEL_FULL);

   // A resync forgives any partial yellow run seen before a fault was cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev    <= RED;
         yel_cnt <= '0;
      end else begin
         prev <= cur;
         if (resync)
            yel_cnt <= YEL_FULL;
         else if (cur != YELLOW)
            yel_cnt <= '0;
         else if (prev != YELLOW)
            yel_cnt <= 5'd1;
         else if (yel_cnt < YEL_FULL)
            yel_cnt <= yel_cnt + 5'd1;
      end
   end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-safety monitor: latches conflict/invalid/illegal/short-yellow faults and flashes red.
// Optional saturating fault event counter under TLC_MON_EVENT_CNT_EN.
module traffic_conflict_monitor
   import tlc_pkg::*;
#(
   parameter int MIN_YEL    = 16,
   parameter int FLASH_HALF = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] highway_light,
   input  logic [1:0] farm_light,
   input  logic       clear_fault,
   output logic [2:0] hw_lamp,
   output logic [2:0] farm_lamp,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [7:0] fault_count
);
   localparam int            FW         = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
   localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

   light_t        hw_code;
   light_t        farm_code;
   logic          hw_illegal;
   logic          hw_short;
   logic          farm_illegal;
   logic          farm_short;
   logic          conflict;
   logic          invalid;
   logic          hard_cause;
   logic          clear_req;
   logic [2:0]    new_code;
   logic          fault_nxt;
   logic [2:0]    code_nxt;
   logic          resync;
   logic          flash_phase;
   logic [FW-1:0] flash_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hw_code   <= RED;
         farm_code <= RED;
      end else begin
         hw_code   <= light_t'(highway_light);
         farm_code <= light_t'(farm_light);
      end
   end

   tlc_approach_checker #(.MIN_YEL(MIN_YEL)) u_hw_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .code      (hw_code),
      .resync    (resync),
      .illegal   (hw_illegal),
      .short_yel (hw_short)
   );

   tlc_approach_checker #(.MIN_YEL(MIN_YEL)) u_farm_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .code      (farm_code),
      .resync    (resync),
      .illegal   (farm_illegal),
      .short_yel (farm_short)
   );

   assign conflict   = (hw_code != RED) && (farm_code != RED);
   assign invalid    = (hw_code == INVALID) || (farm_code == INVALID);
   assign hard_cause = conflict || invalid;
   assign clear_req  = fault && clear_fault;

   // Sequencing causes on a clear cycle stem from pre-clear history, so only live hazards count.
   assign new_code = fault_cause(conflict, invalid,
                                 (hw_illegal || farm_illegal) && !clear_req,
                                 (hw_short || farm_short) && !clear_req);

   always_comb begin
      fault_nxt = fault;
      code_nxt  = fault_code;
      if (!fault) begin
         if (new_code != FC_NONE) begin
            fault_nxt = 1'b1;
            code_nxt  = new_code;
         end
      end else if (clear_fault) begin
         if (hard_cause) begin
            code_nxt = new_code;
         end else begin
            fault_nxt = 1'b0;
            code_nxt  = FC_NONE;
         end
      end
   end

   assign resync = fault && !fault_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault       <= 1'b0;
         fault_code  <= FC_NONE;
         flash_phase <= 1'b0;
         flash_cnt   <= '0;
      end else begin
         fault      <= fault_nxt;
         fault_code <= code_nxt;
         if (!fault_nxt) begin
            flash_phase <= 1'b0;
            flash_cnt   <= '0;
         end else if (!fault) begin
            flash_phase <= 1'b1;
            flash_cnt   <= '0;
         end else if (flash_cnt == FLASH_LAST) begin
            flash_phase <= !flash_phase;
            flash_cnt   <= '0;
         end else begin
            flash_cnt <= flash_cnt + 1'b1;
         end
      end
   end

   assign hw_lamp   = fault ? {flash_phase, 2'b00} : lamp_decode(hw_code);
   assign farm_lamp = fault ? {flash_phase, 2'b00} : lamp_decode(farm_code);

`ifdef TLC_MON_EVENT_CNT_EN
   logic [7:0] event_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         event_cnt <= '0;
      else if (fault_nxt && !fault && (event_cnt != 8'hFF))
         event_cnt <= event_cnt + 8'd1;
   end

   assign fault_count = event_cnt;
`else
   assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: normal sequencing, fault causes,
// clear rules, flash timing, reset and the optional event counter.
module tb_traffic_conflict_monitor;

   localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;
   localparam logic [2:0] LG = 3'b001, LY = 3'b010, LR = 3'b100, LO = 3'b000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] highway_light;
   logic [1:0] farm_light;
   logic       clear_fault;
   logic [2:0] hw_lamp;
   logic [2:0] farm_lamp;
   logic       fault;
   logic [2:0] fault_code;
   logic [7:0] fault_count;

   int n_checks = 0;
   int n_err    = 0;
   int exp_events;
   int cnt_en;

   typedef struct {
      logic [1:0] hw;
      logic [1:0] fm;
      logic       clr;
      int         reps;
      logic [2:0] hwl;
      logic [2:0] fml;
      logic       flt;
      logic [2:0] code;
   } vec_t;

   vec_t tbl[$];

   traffic_conflict_monitor #(.MIN_YEL(16), .FLASH_HALF(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .highway_light (highway_light),
      .farm_light    (farm_light),
      .clear_fault   (clear_fault),
      .hw_lamp       (hw_lamp),
      .farm_lamp     (farm_lamp),
      .fault         (fault),
      .fault_code    (fault_code),
      .fault_count   (fault_count)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] lamp_of(input logic [1:0] c);
      case (c)
         G:       return LG;
         Y:       return LY;
         R:       return LR;
         default: return LO;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] h, input logic [1:0] f, input logic c);
      highway_light = h;
      farm_light    = f;
      clear_fault   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic run_clean(input logic [1:0] h, input logic [1:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         step(h, f, 1'b0);
         chk("seq_hw_lamp", hw_lamp, lamp_of(h));
         chk("seq_farm_lamp", farm_lamp, lamp_of(f));
         chk("seq_no_fault", fault, 1'b0);
      end
   endtask

   task automatic add(input logic [1:0] hw, input logic [1:0] fm, input logic clr, input int reps,
                      input logic [2:0] hwl, input logic [2:0] fml, input logic flt, input logic [2:0] code);
      vec_t v;
      v.hw = hw; v.fm = fm; v.clr = clr; v.reps = reps;
      v.hwl = hwl; v.fml = fml; v.flt = flt; v.code = code;
      tbl.push_back(v);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_hw_lamp"}, hw_lamp, LR);
      chk({tag, "_farm_lamp"}, farm_lamp, LR);
      chk({tag, "_fault"}, fault, 1'b0);
      chk({tag, "_code"}, fault_code, 3'd0);
      chk({tag, "_count"}, fault_count, 8'd0);
   endtask

   initial begin
      logic prev_flt;
`ifdef TLC_MON_EVENT_CNT_EN
      cnt_en = 1;
`else
      cnt_en = 0;
`endif
      // Sequencing boundaries, each fault cause, and the clear rules.
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(Y, R, 0, 16, LY, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(Y, R, 0, 15, LY, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 1, 4);
      add(R, R, 1,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 1, 3);
      add(G, G, 0,  1, LR, LR, 1, 3);
      add(G, G, 1,  1, LR, LR, 1, 1);
      add(R, G, 0,  1, LR, LR, 1, 1);
      add(R, G, 0,  1, LR, LR, 1, 1);
      add(R, G, 1,  1, LR, LG, 0, 0);
      add(R, G, 0,  2, LR, LG, 0, 0);
      add(R, Y, 0, 16, LR, LY, 0, 0);
      add(R, R, 0,  2, LR, LR, 0, 0);
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(Y, R, 0,  5, LY, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 1, 4);
      add(R, R, 1,  1, LR, LR, 0, 0);
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(Y, R, 0,  5, LY, LR, 0, 0);
      add(R, X, 0,  1, LR, LO, 0, 0);
      add(R, R, 0,  1, LR, LR, 1, 2);
      add(R, R, 1,  1, LR, LR, 0, 0);
      add(R, R, 0,  1, LR, LR, 0, 0);
      add(G, R, 0,  1, LG, LR, 0, 0);
      add(Y, R, 0,  2, LY, LR, 0, 0);
      add(Y, X, 0,  1, LY, LO, 0, 0);
      add(Y, R, 0,  1, LR, LR, 1, 1);
      add(Y, R, 1,  1, LY, LR, 0, 0);
      add(R, R, 0,  2, LR, LR, 0, 0);

      rst_n = 1'b0;
      highway_light = R;
      farm_light = R;
      clear_fault = 1'b0;
      #12;
      check_reset_values("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Normal operation: lamps follow inputs one cycle late, never a fault.
      run_clean(G, R, 30);
      run_clean(Y, R, 21);
      run_clean(R, R, 1);
      run_clean(R, G, 21);
      run_clean(R, Y, 21);
      run_clean(R, R, 2);

      exp_events = 0;
      prev_flt = 1'b0;
      foreach (tbl[i]) begin
         for (int r = 0; r < tbl[i].reps; r++)
            step(tbl[i].hw, tbl[i].fm, tbl[i].clr);
         chk($sformatf("row%0d_hw_lamp", i), hw_lamp, tbl[i].hwl);
         chk($sformatf("row%0d_farm_lamp", i), farm_lamp, tbl[i].fml);
         chk($sformatf("row%0d_fault", i), fault, tbl[i].flt);
         chk($sformatf("row%0d_code", i), fault_code, tbl[i].code);
         if (tbl[i].flt && !prev_flt) exp_events++;
         prev_flt = tbl[i].flt;
      end
      chk("table_fault_count", fault_count, (cnt_en != 0) ? 8'(exp_events) : 8'd0);

      // Conflict then flash: 8 cycles lit, 8 dark, repeating.
      step(G, G, 1'b0);
      chk("flash_pre_hw", hw_lamp, LG);
      chk("flash_pre_farm", farm_lamp, LG);
      chk("flash_pre_fault", fault, 1'b0);
      for (int k = 0; k < 26; k++) begin
         step(R, R, 1'b0);
         chk($sformatf("flash%0d_hw", k), hw_lamp, ((k / 8) % 2 == 0) ? LR : LO);
         chk($sformatf("flash%0d_farm", k), farm_lamp, ((k / 8) % 2 == 0) ? LR : LO);
         chk($sformatf("flash%0d_fault", k), fault, 1'b1);
         chk($sformatf("flash%0d_code", k), fault_code, 3'd1);
      end

      // Asynchronous reset in the dark half of the flash.
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("midflash_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      step(G, R, 1'b0);
      chk("post_reset_hw_green", hw_lamp, LG);
      step(G, R, 1'b0);
      chk("post_reset_r2g_legal", fault, 1'b0);

      exp_events = 0;
      for (int c = 0; c < 3; c++) begin
         step(G, G, 1'b0);
         step(R, R, 1'b0);
         chk($sformatf("cycle%0d_fault_set", c), fault, 1'b1);
         chk($sformatf("cycle%0d_code", c), fault_code, 3'd1);
         exp_events++;
         step(R, R, 1'b1);
         chk($sformatf("cycle%0d_cleared", c), fault, 1'b0);
         step(R, R, 1'b0);
         chk($sformatf("cycle%0d_no_refault", c), fault, 1'b0);
      end
      chk("event_count", fault_count, (cnt_en != 0) ? 8'(exp_events) : 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
